// File: rtl/jtag_master.sv
// JTAG master: runs a TAP reset/idle sequence, then executes IR (+ optional DR) shift commands.
// TCK is derived from CLK; TMS/TDI update on the TCK fall and TDO is captured on the TCK rise.
module jtag_master #(
    parameter int CLK_DIV = 2,
    parameter int DR_MAX  = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [3:0]        CMD_IR,
    input  logic [DR_MAX-1:0] CMD_DR,
    input  logic [5:0]        CMD_DR_LEN,
    output logic              TCK,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO,
    output logic              RSP_VALID,
    output logic [DR_MAX-1:0] RSP_DR
);
    typedef enum logic [3:0] {
        INIT, IDLE, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL, DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [6:0] LEN_MAX  = 7'(DR_MAX);

    state_t            state, nxt_state;
    logic [7:0]        div_cnt;
    logic [5:0]        bit_cnt, nxt_bit, len_reg, len_clamped;
    logic [3:0]        ir_reg;
    logic [DR_MAX-1:0] dr_reg, tdo_bit, dr_onehot;
    logic              nxt_tms, nxt_tdi;

    assign len_clamped = ({1'b0, CMD_DR_LEN} > LEN_MAX) ? LEN_MAX[5:0] : CMD_DR_LEN;
    assign tdo_bit     = {{(DR_MAX-1){1'b0}}, TDO} << bit_cnt;
    assign dr_onehot   = {{(DR_MAX-1){1'b0}}, 1'b1} << nxt_bit;

    // Where the FSM goes at the end of the current TCK period, and what that period drives.
    always_comb begin
        nxt_state = state;
        nxt_bit   = bit_cnt + 6'd1;
        case (state)
            INIT:     if (bit_cnt == 6'd5) begin nxt_state = IDLE;     nxt_bit = '0; end
            IR_HDR:   if (bit_cnt == 6'd3) begin nxt_state = IR_SHIFT; nxt_bit = '0; end
            IR_SHIFT: if (bit_cnt == 6'd3) begin nxt_state = IR_TAIL;  nxt_bit = '0; end
            IR_TAIL:  if (bit_cnt == 6'd1) begin
                nxt_state = (len_reg == 6'd0) ? DONE : DR_HDR;
                nxt_bit   = '0;
            end
            DR_HDR:   if (bit_cnt == 6'd2) begin nxt_state = DR_SHIFT; nxt_bit = '0; end
            DR_SHIFT: if (bit_cnt == len_reg - 6'd1) begin nxt_state = DR_TAIL; nxt_bit = '0; end
            DR_TAIL:  if (bit_cnt == 6'd1) begin nxt_state = DONE;     nxt_bit = '0; end
            default: ;
        endcase

        nxt_tms = 1'b0;
        nxt_tdi = 1'b0;
        case (nxt_state)
            INIT:     nxt_tms = (nxt_bit != 6'd5);
            IR_HDR:   nxt_tms = (nxt_bit < 6'd2);
            IR_SHIFT: begin
                nxt_tms = (nxt_bit == 6'd3);
                nxt_tdi = ir_reg[nxt_bit[1:0]];
            end
            IR_TAIL, DR_HDR, DR_TAIL: nxt_tms = (nxt_bit == 6'd0);
            DR_SHIFT: begin
                nxt_tms = (nxt_bit == len_reg - 6'd1);
                nxt_tdi = |(dr_reg & dr_onehot);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= INIT;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            len_reg   <= '0;
            TCK       <= 1'b0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            CMD_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_DR    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        state     <= IR_HDR;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        len_reg   <= len_clamped;
                        TMS       <= 1'b1;
                        TDI       <= 1'b0;
                        CMD_READY <= 1'b0;
                        RSP_DR    <= '0;
                    end
                end
                DONE: begin
                    RSP_VALID <= 1'b0;
                    CMD_READY <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (!TCK) begin
                            TCK <= 1'b1;
                            if (state == DR_SHIFT) RSP_DR <= RSP_DR | tdo_bit;
                        end else begin
                            TCK     <= 1'b0;
                            state   <= nxt_state;
                            bit_cnt <= nxt_bit;
                            TMS     <= nxt_tms;
                            TDI     <= nxt_tdi;
                            if (nxt_state == IDLE) CMD_READY <= 1'b1;
                            if (nxt_state == DONE) RSP_VALID <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Command payload needs no reset: it is only read after an accept has loaded it.
    always_ff @(posedge CLK) begin
        if (CMD_VALID && CMD_READY) begin
            ir_reg <= CMD_IR;
            dr_reg <= CMD_DR;
        end
    end
endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: behavioural TAP controller model plus a response scoreboard.
`timescale 1ns/1ps
module tb_jtag_master;
    localparam int CLK_DIV = 2;
    localparam int DR_MAX  = 32;

    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PDR = 6, EX2DR = 7;
    localparam int UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PIR = 13, EX2IR = 14, UPIR = 15;

    logic        CLK = 1'b0, RST_N = 1'b0, CMD_VALID = 1'b0;
    logic        CMD_READY, TCK, TMS, TDI, TDO, RSP_VALID;
    logic [3:0]  CMD_IR = '0;
    logic [31:0] CMD_DR = '0;
    logic [5:0]  CMD_DR_LEN = '0;
    logic [31:0] RSP_DR;

    int tests = 0, fails = 0, rsp_seen = 0, tdo_mode = 0;

    typedef struct { logic [31:0] rsp; int ntck; } exp_t;
    exp_t sb[$];
    logic tms_log[$];
    logic tdi_log[$];

    int          tap_state = TLR;
    logic [3:0]  tap_ir = 4'h1, tap_irsr = '0;
    logic [31:0] tap_dr = '0;
    logic        tap_tdo = 1'b0;

    jtag_master #(.CLK_DIV(CLK_DIV), .DR_MAX(DR_MAX)) dut (
        .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_IR(CMD_IR), .CMD_DR(CMD_DR), .CMD_DR_LEN(CMD_DR_LEN),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .RSP_VALID(RSP_VALID), .RSP_DR(RSP_DR)
    );

    always #5 CLK = ~CLK;

    // 0: constant 1 (must be ignored), 1: TDI loopback, 2: TAP model
    assign TDO = (tdo_mode == 1) ? TDI : (tdo_mode == 2) ? tap_tdo : 1'b1;

    function automatic int tap_next(input int s, input logic t);
        case (s)
            TLR:   return t ? TLR   : RTI;
            RTI:   return t ? SELDR : RTI;
            SELDR: return t ? SELIR : CAPDR;
            CAPDR: return t ? EX1DR : SHDR;
            SHDR:  return t ? EX1DR : SHDR;
            EX1DR: return t ? UPDR  : PDR;
            PDR:   return t ? EX2DR : PDR;
            EX2DR: return t ? UPDR  : SHDR;
            UPDR:  return t ? SELDR : RTI;
            SELIR: return t ? TLR   : CAPIR;
            CAPIR: return t ? EX1IR : SHIR;
            SHIR:  return t ? EX1IR : SHIR;
            EX1IR: return t ? UPIR  : PIR;
            PIR:   return t ? EX2IR : PIR;
            EX2IR: return t ? UPIR  : SHIR;
            default: return t ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge TCK) begin
        tms_log.push_back(TMS);
        tdi_log.push_back(TDI);
        case (tap_state)
            TLR:   tap_ir   <= 4'h1;
            CAPDR: tap_dr   <= (tap_ir == 4'h1) ? 32'h1234_5677 : 32'h0;
            SHDR:  tap_dr   <= {TDI, tap_dr[31:1]};
            CAPIR: tap_irsr <= 4'b0001;
            SHIR:  tap_irsr <= {TDI, tap_irsr[3:1]};
            UPIR:  tap_ir   <= tap_irsr;
            default: ;
        endcase
        tap_state <= tap_next(tap_state, TMS);
    end

    always @(negedge TCK) tap_tdo <= (tap_state == SHDR) ? tap_dr[0] : 1'b0;

    always @(posedge CLK) begin
        if (RST_N && CMD_VALID && CMD_READY) begin
            tms_log.delete();
            tdi_log.delete();
        end
    end

    // Scoreboard: every RSP_VALID pops the oldest expected response.
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N && RSP_VALID) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_rsp: got RSP_DR=%h, required no response", RSP_DR);
            end else begin
                e = sb.pop_front();
                if (RSP_DR !== e.rsp) begin
                    fails++;
                    $display("FAIL sb_rsp_dr: got %h, required %h", RSP_DR, e.rsp);
                end
                tests++;
                if (tms_log.size() != e.ntck) begin
                    fails++;
                    $display("FAIL sb_tck_count: got %0d, required %0d", tms_log.size(), e.ntck);
                end
            end
            rsp_seen++;
        end
    end

    function automatic logic [127:0] exp_tms(input int len);
        logic [127:0] p;
        int k;
        p = (128'd1 << 0) | (128'd1 << 1);
        k = 4;
        p |= 128'd1 << (k + 3);
        k += 4;
        p |= 128'd1 << k;
        k += 2;
        if (len > 0) begin
            p |= 128'd1 << k;
            k += 3;
            p |= 128'd1 << (k + len - 1);
            k += len;
            p |= 128'd1 << k;
        end
        return p;
    endfunction

    function automatic logic [127:0] log_tms();
        logic [127:0] v = '0;
        for (int i = 0; i < tms_log.size() && i < 128; i++) if (tms_log[i]) v |= 128'd1 << i;
        return v;
    endfunction

    function automatic logic [127:0] log_tdi();
        logic [127:0] v = '0;
        for (int i = 0; i < tdi_log.size() && i < 128; i++) if (tdi_log[i]) v |= 128'd1 << i;
        return v;
    endfunction

    function automatic logic [31:0] len_mask(input int len);
        logic [63:0] m;
        m = (64'd1 << len) - 64'd1;
        return m[31:0];
    endfunction

    task automatic issue(input logic [3:0] ir, input logic [31:0] dr, input logic [5:0] len,
                         input logic [31:0] rsp, input int ntck, output bit ok);
        exp_t e;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (CMD_READY) begin ok = 1'b1; break; end
        end
        if (!ok) return;
        CMD_IR = ir; CMD_DR = dr; CMD_DR_LEN = len; CMD_VALID = 1'b1;
        e.rsp = rsp; e.ntck = ntck;
        sb.push_back(e);
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        CMD_IR = 4'($urandom); CMD_DR = $urandom; CMD_DR_LEN = 6'($urandom);
    endtask

    task automatic wait_rsp(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK); #1;
            if (rsp_seen >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_init();
        int cnt;
        logic [127:0] t;
        cnt = 0;
        tms_log.delete(); tdi_log.delete();
        @(negedge CLK); RST_N = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            cnt++;
            if (CMD_READY) break;
        end
        tests++;
        if (cnt != 24 || CMD_READY !== 1'b1) begin
            fails++;
            $display("FAIL init_ready_latency: got %0d cycles (ready=%b), required 24 (ready=1)", cnt, CMD_READY);
        end
        t = log_tms();
        tests++;
        if (tms_log.size() != 6 || t[5:0] !== 6'b011111) begin
            fails++;
            $display("FAIL init_tms_seq: got %0d bits %b, required 6 bits 011111", tms_log.size(), t[5:0]);
        end
        tests++;
        if (tap_state != RTI || TCK !== 1'b0) begin
            fails++;
            $display("FAIL init_tap_idle: got tap=%0d tck=%b, required tap=%0d tck=0", tap_state, TCK, RTI);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        tests++;
        if ({TCK, TMS, TDI, CMD_READY, RSP_VALID} !== 5'b01000) begin
            fails++;
            $display("FAIL reset_outputs: got tck/tms/tdi/rdy/vld=%b, required 01000",
                     {TCK, TMS, TDI, CMD_READY, RSP_VALID});
        end
        tests++;
        if (RSP_DR !== 32'h0) begin
            fails++;
            $display("FAIL reset_rsp_dr: got %h, required 0", RSP_DR);
        end
        test_init();
    endtask

    task automatic test_ir_only();
        bit ok1, ok2;
        logic [127:0] t, d;
        tdo_mode = 0;
        issue(4'hE, 32'hDEAD_BEEF, 6'd0, 32'h0, 10, ok1);
        wait_rsp(rsp_seen + 1, ok2);
        tests++;
        if (!(ok1 && ok2)) begin
            fails++;
            $display("FAIL ir_only_done: got issue=%b rsp=%b, required 1 1", ok1, ok2);
        end
        t = log_tms(); d = log_tdi();
        tests++;
        if (t !== exp_tms(0)) begin
            fails++;
            $display("FAIL ir_only_tms: got %b, required %b", t[9:0], 10'b0110000011);
        end
        tests++;
        if (d[9:0] !== 10'h0E0) begin
            fails++;
            $display("FAIL ir_only_tdi: got %b, required %b", d[9:0], 10'h0E0);
        end
        @(negedge CLK);
        tests++;
        if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
            fails++;
            $display("FAIL ir_only_pulse: got vld=%b rdy=%b one cycle later, required 0 1", RSP_VALID, CMD_READY);
        end
        tests++;
        if (tap_ir !== 4'hE || tap_state != RTI) begin
            fails++;
            $display("FAIL ir_only_tap: got ir=%h state=%0d, required E %0d", tap_ir, tap_state, RTI);
        end
    endtask

    task automatic test_idcode();
        bit ok1, ok2;
        logic [127:0] t;
        tdo_mode = 2;
        issue(4'h1, 32'h0, 6'd32, 32'h1234_5677, 47, ok1);
        wait_rsp(rsp_seen + 1, ok2);
        t = log_tms();
        tests++;
        if (!(ok1 && ok2) || t !== exp_tms(32)) begin
            fails++;
            $display("FAIL idcode_seq: got done=%b%b tms=%h, required 11 %h", ok1, ok2, t, exp_tms(32));
        end
        tests++;
        if (tap_ir !== 4'h1 || tap_state != RTI) begin
            fails++;
            $display("FAIL idcode_tap: got ir=%h state=%0d, required 1 %0d", tap_ir, tap_state, RTI);
        end
    endtask

    task automatic test_loopback();
        bit ok1, ok2;
        logic [127:0] t, d;
        tdo_mode = 1;
        issue(4'h3, 32'hFFFF_FFA5, 6'd8, 32'h0000_00A5, 23, ok1);
        wait_rsp(rsp_seen + 1, ok2);
        t = log_tms(); d = log_tdi();
        tests++;
        if (!(ok1 && ok2) || t !== exp_tms(8)) begin
            fails++;
            $display("FAIL loopback_tms: got done=%b%b tms=%h, required 11 %h", ok1, ok2, t, exp_tms(8));
        end
        tests++;
        if (t[20:13] !== 8'h80 || d[20:13] !== 8'hA5) begin
            fails++;
            $display("FAIL loopback_dr_bits: got tms=%h tdi=%h, required 80 A5", t[20:13], d[20:13]);
        end
    endtask

    task automatic test_clamp();
        bit ok1, ok2;
        logic [31:0] d;
        d = $urandom;
        tdo_mode = 1;
        issue(4'h2, d, 6'd40, d, 47, ok1);
        wait_rsp(rsp_seen + 1, ok2);
        tests++;
        if (!(ok1 && ok2) || log_tms() !== exp_tms(32)) begin
            fails++;
            $display("FAIL clamp_seq: got done=%b%b tms=%h, required 11 %h", ok1, ok2, log_tms(), exp_tms(32));
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3;
        int len2;
        logic [31:0] d1, d2;
        tdo_mode = 1;
        d1 = $urandom; d2 = $urandom;
        len2 = 1 + int'($urandom_range(0, 31));
        issue(4'h6, d1, 6'd1, d1 & len_mask(1), 16, ok1);
        issue(4'h7, d2, 6'(len2), d2 & len_mask(len2), 15 + len2, ok2);
        wait_rsp(rsp_seen + 1, ok3);
        tests++;
        if (!(ok1 && ok2 && ok3) || sb.size() != 0) begin
            fails++;
            $display("FAIL b2b_done: got done=%b%b%b pending=%0d, required 111 0", ok1, ok2, ok3, sb.size());
        end
        repeat (30) @(negedge CLK);
        tests++;
        if (RSP_DR !== (d2 & len_mask(len2))) begin
            fails++;
            $display("FAIL b2b_rsp_hold: got %h, required %h", RSP_DR, d2 & len_mask(len2));
        end
    endtask

    task automatic test_abort();
        bit ok1, ok2, hit;
        int seen0;
        tdo_mode = 1;
        hit = 1'b0;
        issue(4'h5, 32'h0000_FFFF, 6'd16, 32'h0000_FFFF, 31, ok1);
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (tms_log.size() >= 19) begin hit = 1'b1; break; end
        end
        tests++;
        if (!(ok1 && hit)) begin
            fails++;
            $display("FAIL abort_reach_bit5: got issue=%b reached=%b, required 1 1", ok1, hit);
        end
        RST_N = 1'b0;
        #1;
        tests++;
        if ({TCK, TMS, CMD_READY, RSP_VALID} !== 4'b0100 || RSP_DR !== 32'h0) begin
            fails++;
            $display("FAIL abort_reset_outputs: got tck/tms/rdy/vld=%b rsp=%h, required 0100 0",
                     {TCK, TMS, CMD_READY, RSP_VALID}, RSP_DR);
        end
        seen0 = rsp_seen;
        repeat (5) @(negedge CLK);
        sb.delete();
        test_init();
        tests++;
        if (rsp_seen != seen0) begin
            fails++;
            $display("FAIL abort_no_rsp: got %0d responses, required %0d", rsp_seen, seen0);
        end
        issue(4'h9, 32'h0000_000C, 6'd4, 32'h0000_000C, 19, ok1);
        wait_rsp(rsp_seen + 1, ok2);
        tests++;
        if (!(ok1 && ok2)) begin
            fails++;
            $display("FAIL abort_recover: got issue=%b rsp=%b, required 1 1", ok1, ok2);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ir_only();
        test_idcode();
        test_loopback();
        test_clamp();
        test_back_to_back();
        test_abort();
        repeat (4) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 Parameter CLK_DIV, default 2: CLK cycles per TCK half-period; legal values are 1..255.
REQ-002 Parameter DR_MAX, default 32: maximum DR shift length in bits.
REQ-003 Port CLK, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port CMD_VALID, input, 1 bit: a command is offered.
REQ-006 Port CMD_READY, output, 1 bit: the master accepts a command.
REQ-007 Port CMD_IR, input, 4 bits: instruction to load, shifted LSB first.
REQ-008 Port CMD_DR, input, DR_MAX bits: DR data to shift, LSB first.
REQ-009 Port CMD_DR_LEN, input, 6 bits: DR length. 0 means IR-only; values above DR_MAX are clamped to DR_MAX.
REQ-010 Port TCK, output, 1 bit: generated test clock.
REQ-011 Port TMS, output, 1 bit: test mode select.
REQ-012 Port TDI, output, 1 bit: test data to the TAP.
REQ-013 Port TDO, input, 1 bit: test data from the TAP.
REQ-014 Port RSP_VALID, output, 1 bit: one-CLK pulse marking command completion.
REQ-015 Port RSP_DR, output, DR_MAX bits: captured TDO bits, LSB first, zero-extended.

Function
REQ-016 TCK SHALL idle low. Each TCK period is 2*CLK_DIV CLK cycles: a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
REQ-017 TMS and TDI SHALL change only at the start of a TCK low phase, i.e. on the TCK falling edge.
REQ-018 TDO SHALL be sampled in the CLK cycle in which TCK goes high.
REQ-019 FSM states SHALL be: INIT, IDLE, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL, DONE.
REQ-020 INIT SHALL drive 6 TCK cycles with TMS = 1,1,1,1,1,0, then go to IDLE. This places the TAP in Run-Test/Idle.
REQ-021 CMD_READY SHALL be 1 only in IDLE. A command is accepted on a CLK edge where CMD_VALID and CMD_READY are both 1. CMD_IR, CMD_DR and the clamped length SHALL be registered on that edge.
REQ-022 IR_HDR SHALL drive TMS = 1,1,0,0 over 4 TCK cycles, with TDI = 0.
REQ-023 IR_SHIFT SHALL drive 4 TCK cycles with TDI = CMD_IR[i] for i = 0..3. TMS = 0 on bits 0..2 and TMS = 1 on bit 3.
REQ-024 IR_TAIL SHALL drive TMS = 1,0 over 2 TCK cycles.
REQ-025 From IR_TAIL, the FSM SHALL go to DONE when the length is 0, otherwise to DR_HDR.
REQ-026 DR_HDR SHALL drive TMS = 1,0,0 over 3 TCK cycles.
REQ-027 DR_SHIFT SHALL drive N TCK cycles with TDI = CMD_DR[i]. TMS = 1 only on bit N-1. TDO sampled on bit i SHALL be stored to RSP_DR[i].
REQ-028 DR_TAIL SHALL drive TMS = 1,0 over 2 TCK cycles, then go to DONE.
REQ-029 An IR-only command SHALL total 10 TCK cycles. An IR+DR command SHALL total 15+N TCK cycles.
REQ-030 DONE SHALL pulse RSP_VALID for exactly one CLK, then return to IDLE with CMD_READY = 1 on the following cycle.
REQ-031 RSP_DR SHALL be cleared to 0 at command accept. It SHALL hold its value from completion until the next accept.
REQ-032 Changes on CMD_* after accept SHALL have no effect on the command in progress.
REQ-033 TDO SHALL be ignored outside DR_SHIFT.

Reset
REQ-034 While RST_N = 0, outputs SHALL be: TCK = 0, TMS = 1, TDI = 0, CMD_READY = 0, RSP_VALID = 0, RSP_DR = 0. The FSM SHALL be in INIT and all counters at 0.
REQ-035 After RST_N deasserts, the INIT sequence of REQ-020 SHALL run before CMD_READY rises.
REQ-036 RST_N asserted mid-command SHALL abort the command immediately and produce no RSP_VALID. The next command SHALL be preceded by a full INIT sequence.

Verification
REQ-037 Release reset with CLK_DIV = 2 -> TMS = 1,1,1,1,1,0 over 6 TCK cycles (24 CLK cycles), then CMD_READY = 1.
REQ-038 Accept CMD_IR = 4'hE, CMD_DR_LEN = 0 -> 10 TCK cycles with TMS = 1,1,0,0,0,0,0,1,1,0 and TDI bits 0,1,1,1 during IR_SHIFT; then one RSP_VALID pulse with RSP_DR = 0.
REQ-039 Accept CMD_IR = 4'h1, CMD_DR_LEN = 32, CMD_DR = 0, with a TAP model returning IDCODE 32'h1234_5677 -> 47 TCK cycles; RSP_DR = 32'h1234_5677.
REQ-040 Accept CMD_DR_LEN = 8, CMD_DR = 8'hA5, with TDO looped back from TDI -> RSP_DR = 32'h0000_00A5; TMS = 1 only on DR bit 7.
REQ-041 Accept CMD_DR_LEN = 40 -> treated as 32: 47 TCK cycles in total.
REQ-042 Assert RST_N = 0 during DR_SHIFT bit 5 -> TCK = 0 immediately and no RSP_VALID; after release, the 6-cycle INIT sequence repeats before CMD_READY = 1.
